// File: rtl/fpu_pkg.sv
// Shared constants, state encoding and latency lookup for the FP issue controller.
// Pure declarations: no latency, no flow control.
package fpu_pkg;

    localparam logic [6:0] OPC_OP_FP = 7'b1010011;

    localparam logic [4:0] FUNCT5_ADD     = 5'b00000;
    localparam logic [4:0] FUNCT5_SUB     = 5'b00001;
    localparam logic [4:0] FUNCT5_MUL     = 5'b00010;
    localparam logic [4:0] FUNCT5_DIV     = 5'b00011;
    localparam logic [4:0] FUNCT5_SQRT    = 5'b01011;
    localparam logic [4:0] FUNCT5_CVT_L_D = 5'b11000;
    localparam logic [4:0] FUNCT5_CVT_D_L = 5'b11010;

    localparam logic [2:0] FPU_OP_ADD     = 3'b000;
    localparam logic [2:0] FPU_OP_SUB     = 3'b001;
    localparam logic [2:0] FPU_OP_MUL     = 3'b010;
    localparam logic [2:0] FPU_OP_DIV     = 3'b011;
    localparam logic [2:0] FPU_OP_SQRT    = 3'b100;
    localparam logic [2:0] FPU_OP_CVT_L_D = 3'b101;
    localparam logic [2:0] FPU_OP_CVT_D_L = 3'b110;
    localparam logic [2:0] FPU_OP_NONE    = 3'b111;

    localparam logic [1:0] FMT_S = 2'b00;
    localparam logic [1:0] FMT_D = 2'b01;

    localparam logic [4:0] RS2_SQRT = 5'b00000;
    localparam logic [4:0] RS2_CVT  = 5'b00010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Latencies are passed in because they are parameters of the instantiating module.
    function automatic int unsigned lat_of(
        input logic [2:0]  op,
        input int unsigned lat_add,
        input int unsigned lat_mul,
        input int unsigned lat_div,
        input int unsigned lat_sqrt,
        input int unsigned lat_cvt
    );
        case (op)
            FPU_OP_ADD, FPU_OP_SUB:         lat_of = lat_add;
            FPU_OP_MUL:                     lat_of = lat_mul;
            FPU_OP_DIV:                     lat_of = lat_div;
            FPU_OP_SQRT:                    lat_of = lat_sqrt;
            FPU_OP_CVT_L_D, FPU_OP_CVT_D_L: lat_of = lat_cvt;
            default:                        lat_of = 1;
        endcase
    endfunction

endpackage

// File: rtl/fpu_op_decode.sv
// Combinational OP-FP decoder: instr -> {op, legal}, op forced to NONE when illegal.
// Zero latency; no flow control.
module fpu_op_decode
    import fpu_pkg::*;
#(
    parameter bit EN_SP = 1'b0
) (
    input  logic [31:0] instr,
    output logic [2:0]  op,
    output logic        legal
);

    logic [4:0] funct5;
    logic [1:0] fmt;
    logic [4:0] rs2;
    logic [6:0] opcode;
    logic [2:0] op_raw;
    logic       rs2_ok;
    logic       fmt_ok;
    logic       unused_instr;

    assign funct5       = instr[31:27];
    assign fmt          = instr[26:25];
    assign rs2          = instr[24:20];
    assign opcode       = instr[6:0];
    assign unused_instr = ^instr[19:7];

    always_comb begin
        op_raw = FPU_OP_NONE;
        rs2_ok = 1'b1;
        case (funct5)
            FUNCT5_ADD:  op_raw = FPU_OP_ADD;
            FUNCT5_SUB:  op_raw = FPU_OP_SUB;
            FUNCT5_MUL:  op_raw = FPU_OP_MUL;
            FUNCT5_DIV:  op_raw = FPU_OP_DIV;
            FUNCT5_SQRT: begin
                op_raw = FPU_OP_SQRT;
                rs2_ok = (rs2 == RS2_SQRT);
            end
            FUNCT5_CVT_L_D: begin
                op_raw = FPU_OP_CVT_L_D;
                rs2_ok = (rs2 == RS2_CVT);
            end
            FUNCT5_CVT_D_L: begin
                op_raw = FPU_OP_CVT_D_L;
                rs2_ok = (rs2 == RS2_CVT);
            end
            default: op_raw = FPU_OP_NONE;
        endcase
        fmt_ok = (fmt == FMT_D) || (EN_SP && (fmt == FMT_S));
        legal  = (opcode == OPC_OP_FP) && (op_raw != FPU_OP_NONE) && fmt_ok && rs2_ok;
        op     = legal ? op_raw : FPU_OP_NONE;
    end

endmodule

// File: rtl/fpu_issue_cntrl.sv
// FP issue controller: accepts one OP-FP instr, pulses start one cycle later, completes LAT(op) cycles after start;
// in_ready low while busy or while a completion waits for out_ready; flush kills in-flight work.
module fpu_issue_cntrl
    import fpu_pkg::*;
#(
    parameter bit          EN_SP    = 1'b0,
    parameter int unsigned LAT_ADD  = 3,
    parameter int unsigned LAT_MUL  = 4,
    parameter int unsigned LAT_DIV  = 20,
    parameter int unsigned LAT_SQRT = 24,
    parameter int unsigned LAT_CVT  = 2,
    parameter int unsigned CNT_W    = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    output logic        start,
    output logic [2:0]  fpu_op,
    output logic [1:0]  fpu_fmt,
    output logic [4:0]  rd_tag,
    output logic        busy,
    output logic        illegal,
    output logic        kill,
    output logic        out_valid,
    input  logic        out_ready
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [1:0]       fmt_q, fmt_d;
    logic [4:0]       rd_q, rd_d;
    logic             start_q, start_d;
    logic             illegal_q, illegal_d;
    logic             kill_q, kill_d;
    logic [2:0]       dec_op;
    logic             dec_legal;
    logic             accept;

    fpu_op_decode #(.EN_SP(EN_SP)) u_dec (
        .instr (in_instr),
        .op    (dec_op),
        .legal (dec_legal)
    );

    assign in_ready = !flush && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready));
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        fmt_d     = fmt_q;
        rd_d      = rd_q;
        start_d   = 1'b0;
        illegal_d = 1'b0;
        kill_d    = 1'b0;
        if (flush) begin
            kill_d  = (state_q != ST_IDLE);
            state_d = ST_IDLE;
            cnt_d   = '0;
            op_d    = FPU_OP_NONE;
        end else begin
            case (state_q)
                ST_BUSY: begin
                    if (cnt_q == '0) state_d = ST_DONE;
                    else             cnt_d   = cnt_q - CNT_W'(1);
                end
                ST_DONE: if (out_ready) state_d = ST_IDLE;
                default: state_d = state_q;
            endcase
            // A DONE handoff and a new accept share the edge, so the next op issues with no bubble.
            if (accept) begin
                if (dec_legal) begin
                    state_d = ST_BUSY;
                    op_d    = dec_op;
                    fmt_d   = in_instr[26:25];
                    rd_d    = in_instr[11:7];
                    start_d = 1'b1;
                    cnt_d   = CNT_W'(lat_of(dec_op, LAT_ADD, LAT_MUL, LAT_DIV, LAT_SQRT, LAT_CVT) - 1);
                end else begin
                    state_d   = ST_IDLE;
                    op_d      = FPU_OP_NONE;
                    illegal_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            op_q      <= FPU_OP_NONE;
            fmt_q     <= '0;
            rd_q      <= '0;
            start_q   <= 1'b0;
            illegal_q <= 1'b0;
            kill_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            fmt_q     <= fmt_d;
            rd_q      <= rd_d;
            start_q   <= start_d;
            illegal_q <= illegal_d;
            kill_q    <= kill_d;
        end
    end

    assign start     = start_q;
    assign illegal   = illegal_q;
    assign kill      = kill_q;
    assign fpu_op    = op_q;
    assign fpu_fmt   = fmt_q;
    assign rd_tag    = rd_q;
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = (state_q == ST_DONE);

endmodule

// File: tb/tb_fpu_issue_cntrl.sv
// Bench for fpu_issue_cntrl: vector table, directed multi-cycle sequences, then random traffic vs a timeline model.
module tb_fpu_issue_cntrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_valid_sp = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_instr = 32'h0;

    logic       in_ready, start, busy, illegal, kill, out_valid;
    logic [2:0] fpu_op;
    logic [1:0] fpu_fmt;
    logic [4:0] rd_tag;

    logic       in_ready_sp, start_sp, busy_sp, illegal_sp, kill_sp, out_valid_sp;
    logic [2:0] fpu_op_sp;
    logic [1:0] fpu_fmt_sp;
    logic [4:0] rd_tag_sp;

    int checks = 0;
    int failures = 0;

    localparam logic [31:0] I_FADD_D   = 32'h023100D3;
    localparam logic [31:0] I_FDIV_D   = 32'h1A3100D3;
    localparam logic [31:0] I_FMUL_RD5 = 32'h123102D3;
    localparam logic [31:0] I_FADD_S   = 32'h003100D3;

    always #5 clk = ~clk;

    fpu_issue_cntrl #(.EN_SP(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .start(start), .fpu_op(fpu_op), .fpu_fmt(fpu_fmt), .rd_tag(rd_tag),
        .busy(busy), .illegal(illegal), .kill(kill), .out_valid(out_valid), .out_ready(out_ready)
    );

    fpu_issue_cntrl #(.EN_SP(1'b1)) dut_sp (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid_sp), .in_ready(in_ready_sp),
        .in_instr(in_instr), .start(start_sp), .fpu_op(fpu_op_sp), .fpu_fmt(fpu_fmt_sp), .rd_tag(rd_tag_sp),
        .busy(busy_sp), .illegal(illegal_sp), .kill(kill_sp), .out_valid(out_valid_sp), .out_ready(out_ready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference decode straight from the ISA rules: op code, legality and latency.
    function automatic void ref_decode(input logic [31:0] ins, input bit en_sp,
                                       output logic [2:0] op, output bit legal, output int lat);
        int rs2_need;
        logic [1:0] fmt;
        rs2_need = -1;
        fmt = ins[26:25];
        op = 3'd7;
        lat = 0;
        case (ins[31:27])
            5'b00000: begin op = 3'd0; lat = 3; end
            5'b00001: begin op = 3'd1; lat = 3; end
            5'b00010: begin op = 3'd2; lat = 4; end
            5'b00011: begin op = 3'd3; lat = 20; end
            5'b01011: begin op = 3'd4; lat = 24; rs2_need = 0; end
            5'b11000: begin op = 3'd5; lat = 2;  rs2_need = 2; end
            5'b11010: begin op = 3'd6; lat = 2;  rs2_need = 2; end
            default: ;
        endcase
        legal = (ins[6:0] == 7'b1010011) && (op != 3'd7) &&
                ((fmt == 2'b01) || (en_sp && fmt == 2'b00)) &&
                ((rs2_need < 0) || (int'(ins[24:20]) == rs2_need));
        if (!legal) op = 3'd7;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 7))
            0: r[31:27] = 5'b00000;
            1: r[31:27] = 5'b00001;
            2: r[31:27] = 5'b00010;
            3: r[31:27] = 5'b00011;
            4: r[31:27] = 5'b01011;
            5: r[31:27] = 5'b11000;
            6: r[31:27] = 5'b11010;
            default: r[31:27] = 5'b00100;
        endcase
        if ($urandom_range(0, 7) != 0) r[6:0] = 7'b1010011;
        if ($urandom_range(0, 3) != 0) r[26:25] = 2'b01;
        if ($urandom_range(0, 3) != 0) begin
            if (r[31:27] == 5'b01011) r[24:20] = 5'b00000;
            if (r[31:27] == 5'b11000 || r[31:27] == 5'b11010) r[24:20] = 5'b00010;
        end
        return r;
    endfunction

    typedef struct {
        logic [31:0] instr;
        logic        legal;
        logic [2:0]  op;
        logic [1:0]  fmt;
        logic [4:0]  rd;
        int          lat;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    initial begin
        int n;
        bit seen;
        bit pend, e_start, e_ill, e_kill, e_ov, e_rdy, d_legal;
        logic [2:0] m_op, d_op;
        logic [1:0] m_fmt;
        logic [4:0] m_rd;
        int ready_cyc, cyc, d_lat;

        vecs[0]  = '{32'h023100D3, 1'b1, 3'd0, 2'b01, 5'd1,  3};
        vecs[1]  = '{32'h02310FD3, 1'b1, 3'd0, 2'b01, 5'd31, 3};
        vecs[2]  = '{32'h0A3100D3, 1'b1, 3'd1, 2'b01, 5'd1,  3};
        vecs[3]  = '{32'h123100D3, 1'b1, 3'd2, 2'b01, 5'd1,  4};
        vecs[4]  = '{32'h1A3100D3, 1'b1, 3'd3, 2'b01, 5'd1,  20};
        vecs[5]  = '{32'h5A0100D3, 1'b1, 3'd4, 2'b01, 5'd1,  24};
        vecs[6]  = '{32'hC22100D3, 1'b1, 3'd5, 2'b01, 5'd1,  2};
        vecs[7]  = '{32'hD22100D3, 1'b1, 3'd6, 2'b01, 5'd1,  2};
        vecs[8]  = '{32'h5A3100D3, 1'b0, 3'd7, 2'b01, 5'd1,  0};
        vecs[9]  = '{32'h003100D3, 1'b0, 3'd7, 2'b00, 5'd1,  0};
        vecs[10] = '{32'hC23100D3, 1'b0, 3'd7, 2'b01, 5'd1,  0};
        vecs[11] = '{32'h023100D7, 1'b0, 3'd7, 2'b01, 5'd1,  0};
        vecs[12] = '{32'h223100D3, 1'b0, 3'd7, 2'b01, 5'd1,  0};

        // Reset values observed while reset is held.
        repeat (2) @(negedge clk);
        chk("rst_start", start, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_kill", kill, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fpu_op", fpu_op, 3'b111);
        chk("rst_fmt", fpu_fmt, 0);
        chk("rst_rd", rd_tag, 0);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_instr = vecs[i].instr;
            out_ready = 1'b1;
            #1 chk("vec_in_ready", in_ready, 1);
            @(negedge clk);
            in_valid = 1'b0;
            chk("vec_start", start, vecs[i].legal);
            chk("vec_illegal", illegal, !vecs[i].legal);
            chk("vec_op", fpu_op, vecs[i].legal ? vecs[i].op : 3'b111);
            chk("vec_busy", busy, vecs[i].legal);
            if (vecs[i].legal) begin
                chk("vec_fmt", fpu_fmt, vecs[i].fmt);
                chk("vec_rd", rd_tag, vecs[i].rd);
                n = 0;
                while (!out_valid && n < 40) begin
                    @(negedge clk);
                    n++;
                    if (n == 1) chk("vec_start_pulse", start, 0);
                end
                chk("vec_latency", n, vecs[i].lat);
            end
            @(negedge clk);
            chk("vec_idle", busy, 0);
            chk("vec_illegal_pulse", illegal, 0);
        end

        // fdiv with writeback stalled: completion held and input blocked until handshake.
        @(negedge clk);
        in_valid = 1'b1; in_instr = I_FDIV_D; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        chk("div_start", start, 1);
        n = 0;
        while (!out_valid && n < 40) begin @(negedge clk); n++; end
        chk("div_latency", n, 20);
        in_valid = 1'b1; in_instr = I_FMUL_RD5;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("div_hold_ready", in_ready, 0);
            chk("div_hold_valid", out_valid, 1);
            chk("div_hold_rd", rd_tag, 1);
            chk("div_hold_op", fpu_op, 3'd3);
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        #1 chk("div_release_ready", in_ready, 1);
        @(negedge clk);
        chk("div_release_busy", busy, 0);
        chk("div_release_valid", out_valid, 0);
        chk("div_release_start", start, 0);

        // Back-to-back: new fmul accepted on the completion cycle.
        @(negedge clk);
        in_valid = 1'b1; in_instr = I_FADD_D; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin @(negedge clk); n++; end
        chk("b2b_first_latency", n, 3);
        in_valid = 1'b1; in_instr = I_FMUL_RD5;
        #1 chk("b2b_in_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b_start", start, 1);
        chk("b2b_op", fpu_op, 3'd2);
        chk("b2b_rd", rd_tag, 5);
        chk("b2b_busy", busy, 1);
        chk("b2b_out_valid", out_valid, 0);
        n = 0;
        while (!out_valid && n < 40) begin @(negedge clk); n++; end
        chk("b2b_second_latency", n, 4);
        @(negedge clk);
        chk("b2b_idle", busy, 0);

        // Flush in the fifth busy cycle of fdiv; the op offered that cycle must be refused.
        @(negedge clk);
        in_valid = 1'b1; in_instr = I_FDIV_D;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("flush_pre_busy", busy, 1);
        flush = 1'b1; in_valid = 1'b1; in_instr = I_FADD_D;
        #1 chk("flush_in_ready", in_ready, 0);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_kill", kill, 1);
        chk("flush_busy", busy, 0);
        chk("flush_op", fpu_op, 3'b111);
        chk("flush_no_start", start, 0);
        @(negedge clk);
        chk("flush_kill_pulse", kill, 0);
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid || busy) seen = 1'b1;
        end
        chk("flush_no_completion", seen, 0);

        // Flush while idle does nothing.
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_idle_kill", kill, 0);
        chk("flush_idle_busy", busy, 0);

        // Asynchronous reset in the start cycle.
        in_valid = 1'b1; in_instr = I_FDIV_D;
        @(negedge clk);
        in_valid = 1'b0;
        chk("arst_pre_start", start, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_start", start, 0);
        chk("arst_busy", busy, 0);
        chk("arst_op", fpu_op, 3'b111);
        chk("arst_rd", rd_tag, 0);
        chk("arst_fmt", fpu_fmt, 0);
        chk("arst_out_valid", out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_kill", kill, 0);
        chk("arst_idle", busy, 0);

        // Single precision accepted only when enabled.
        in_valid_sp = 1'b1; in_instr = I_FADD_S; out_ready = 1'b1;
        @(negedge clk);
        in_valid_sp = 1'b0;
        chk("sp_start", start_sp, 1);
        chk("sp_illegal", illegal_sp, 0);
        chk("sp_op", fpu_op_sp, 3'd0);
        chk("sp_fmt", fpu_fmt_sp, 2'b00);
        n = 0;
        while (!out_valid_sp && n < 40) begin @(negedge clk); n++; end
        chk("sp_latency", n, 3);

        // Random traffic against a timeline model (absolute completion cycle per op).
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        pend = 1'b0; e_start = 1'b0; e_ill = 1'b0; e_kill = 1'b0;
        m_op = 3'd7; m_fmt = 2'b00; m_rd = 5'd0; ready_cyc = 0; cyc = 0;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 1) == 1);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            in_instr  = rand_instr();
            #1;
            e_ov  = pend && (cyc >= ready_cyc);
            e_rdy = !flush && (!pend || (e_ov && out_ready));
            chk("rnd_in_ready", in_ready, e_rdy);
            chk("rnd_out_valid", out_valid, e_ov);
            chk("rnd_busy", busy, pend);
            chk("rnd_start", start, e_start);
            chk("rnd_illegal", illegal, e_ill);
            chk("rnd_kill", kill, e_kill);
            chk("rnd_op", fpu_op, m_op);
            chk("rnd_fmt", fpu_fmt, m_fmt);
            chk("rnd_rd", rd_tag, m_rd);
            e_start = 1'b0; e_ill = 1'b0; e_kill = 1'b0;
            if (flush) begin
                e_kill = pend;
                pend = 1'b0;
                m_op = 3'd7;
            end else begin
                if (e_ov && out_ready) pend = 1'b0;
                if (in_valid && e_rdy) begin
                    ref_decode(in_instr, 1'b0, d_op, d_legal, d_lat);
                    if (d_legal) begin
                        pend = 1'b1;
                        m_op = d_op;
                        m_fmt = in_instr[26:25];
                        m_rd = in_instr[11:7];
                        e_start = 1'b1;
                        ready_cyc = cyc + 1 + d_lat;
                    end else begin
                        e_ill = 1'b1;
                        m_op = 3'd7;
                    end
                end
            end
            cyc++;
        end
        in_valid = 1'b0; flush = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
